gsr_release_sequencer: RTL and testbench

Generates the active-low global set/reset net that the library's GSR-enabled flip-flop primitives sample. It sits directly upstream of those registers. It converts an asynchronous board reset into a glitch-free, clock-synchronous release. Release is held off until the PLL reports lock and a minimum hold time has elapsed. A software re-reset request is also supported.

---
 rtl/gsr_release_sequencer.sv | 148 ++++++++++++++
 tb/tb_gsr_release_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/gsr_release_sequencer.sv
// Active-low global set/reset generator: synchronizes board reset release,
// qualifies PLL lock for a hold period, and supports software re-reset.
module gsr_release_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int SW_HOLD_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic       CK,
  input  logic       RSTN,
  input  logic       LOCK,
  input  logic       SWRST_REQ,
  output logic       GSRN,
  output logic       READY,
  output logic       SWRST_ACK,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_HOLD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_SWRST   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_rst_sync;
  logic                   r_lock_meta;
  logic                   r_lock_sync;
  logic [CNT_W-1:0]       r_cnt;
  state_t                 r_state;
  logic                   r_gsrn;
  logic                   r_ready;
  logic                   r_ack;

  logic w_rst_done;
  logic w_hold_last;
  logic w_sw_last;

  assign w_rst_done  = r_rst_sync[SYNC_STAGES-1];
  assign w_hold_last = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign w_sw_last   = (r_cnt == CNT_W'(SW_HOLD_CYCLES - 1));

  // Reset-release synchronizer: asserts asynchronously, releases after SYNC_STAGES edges
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_rst_sync <= '0;
    end else begin
      r_rst_sync <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // LOCK synchronizer, held clear until the FSM leaves RESET so it is primed in HOLD
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else if (r_state == S_RESET) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= LOCK;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Sequencer FSM with registered GSRN/READY/ACK
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_gsrn  <= 1'b0;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_RESET: begin
          r_gsrn  <= 1'b0;
          r_ready <= 1'b0;
          r_cnt   <= '0;
          if (w_rst_done) begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_ready <= 1'b0;
          if (!r_lock_sync) begin
            r_cnt  <= '0;
            r_gsrn <= 1'b0;
          end else if (w_hold_last) begin
            r_state <= S_RELEASE;
            r_cnt   <= '0;
            r_gsrn  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_gsrn <= 1'b0;
          end
        end
        S_RELEASE: begin
          r_state <= S_RUN;
          r_gsrn  <= 1'b1;
          r_ready <= 1'b1;
        end
        S_RUN: begin
          // Software request takes priority over a simultaneous lock loss
          if (SWRST_REQ) begin
            r_state <= S_SWRST;
            r_gsrn  <= 1'b0;
            r_ready <= 1'b0;
            r_ack   <= 1'b1;
            r_cnt   <= '0;
          end else if (!r_lock_sync) begin
            r_state <= S_HOLD;
            r_gsrn  <= 1'b0;
            r_ready <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_gsrn  <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        S_SWRST: begin
          r_gsrn  <= 1'b0;
          r_ready <= 1'b0;
          if (w_sw_last) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_RESET;
          r_cnt   <= '0;
          r_gsrn  <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign GSRN      = r_gsrn;
  assign READY     = r_ready;
  assign SWRST_ACK = r_ack;
  assign STATE     = r_state;

endmodule

// File: tb/tb_gsr_release_sequencer.sv
// Directed bench for gsr_release_sequencer: table-driven power-up/SWRST rows
// plus hand-written sequences for lock glitch, lock loss, held request and async reset.
module tb_gsr_release_sequencer;

  logic       CK;
  logic       RSTN;
  logic       LOCK;
  logic       SWRST_REQ;
  logic       GSRN;
  logic       READY;
  logic       SWRST_ACK;
  logic [2:0] STATE;

  int n_cmp;
  int n_err;

  typedef struct {
    int         adv;
    logic       lock;
    logic       swreq;
    logic       gsrn;
    logic       ready;
    logic       ack;
    logic [2:0] st;
  } vec_t;

  vec_t tbl [12];

  gsr_release_sequencer dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .LOCK      (LOCK),
    .SWRST_REQ (SWRST_REQ),
    .GSRN      (GSRN),
    .READY     (READY),
    .SWRST_ACK (SWRST_ACK),
    .STATE     (STATE)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic g, input logic r,
                         input logic a, input logic [2:0] s);
    chk({nm, ".gsrn"},  int'(GSRN),      int'(g));
    chk({nm, ".ready"}, int'(READY),     int'(r));
    chk({nm, ".ack"},   int'(SWRST_ACK), int'(a));
    chk({nm, ".state"}, int'(STATE),     int'(s));
  endtask

  task automatic apply_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      LOCK      = tbl[i].lock;
      SWRST_REQ = tbl[i].swreq;
      repeat (tbl[i].adv) tick();
      chk_all($sformatf("row%0d", i), tbl[i].gsrn, tbl[i].ready, tbl[i].ack, tbl[i].st);
    end
  endtask

  // Holds reset, checks reset values, releases RSTN so the next edge is edge 1
  task automatic do_reset();
    RSTN      = 1'b0;
    LOCK      = 1'b1;
    SWRST_REQ = 1'b0;
    repeat (3) tick();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    RSTN = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    // Power-up with LOCK stable: GSRN at edge 21, READY at edge 22
    tbl[0]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[2]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[3]  = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
    tbl[4]  = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};
    // One-cycle software request, then 8 SWRST + 16 HOLD + 1 RELEASE
    tbl[5]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4};
    tbl[6]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
    tbl[7]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
    tbl[8]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[9]  = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    tbl[10] = '{1,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
    tbl[11] = '{1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3};

    RSTN      = 1'b0;
    LOCK      = 1'b1;
    SWRST_REQ = 1'b0;
    #2;
    chk_all("async_reset_t0", 1'b0, 1'b0, 1'b0, 3'd0);

    do_reset();
    apply_rows(0, 11);

    // Lock glitch seen at HOLD count 10: release moves from edge 21 to 32
    do_reset();
    repeat (13) tick();
    LOCK = 1'b0;
    tick();
    LOCK = 1'b1;
    repeat (17) tick();
    chk_all("glitch_e31", 1'b0, 1'b0, 1'b0, 3'd1);
    tick();
    chk_all("glitch_e32", 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    chk_all("glitch_e33", 1'b1, 1'b1, 1'b0, 3'd3);

    // Lock loss in RUN: back to HOLD after the synchronizer, no ACK
    LOCK = 1'b0;
    tick();
    chk_all("lockloss_e1", 1'b1, 1'b1, 1'b0, 3'd3);
    tick();
    chk("lockloss_e2.ack", int'(SWRST_ACK), 0);
    tick();
    chk_all("lockloss_e3", 1'b0, 1'b0, 1'b0, 3'd1);

    // Request held through HOLD/RELEASE is ignored until the first RUN cycle
    SWRST_REQ = 1'b1;
    LOCK      = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("held_req_hold%0d.ack", i), int'(SWRST_ACK), 0);
    end
    tick();
    chk_all("held_req_release", 1'b1, 1'b0, 1'b0, 3'd2);
    tick();
    chk_all("held_req_run", 1'b1, 1'b1, 1'b0, 3'd3);
    tick();
    chk_all("held_req_swrst", 1'b0, 1'b0, 1'b1, 3'd4);
    SWRST_REQ = 1'b0;
    tick();
    chk_all("held_req_ack_end", 1'b0, 1'b0, 1'b0, 3'd4);

    // Async reset mid-SWRST between edges, then the full power-up repeats
    repeat (2) tick();
    #3;
    RSTN = 1'b0;
    #1;
    chk_all("midswrst_async", 1'b0, 1'b0, 1'b0, 3'd0);
    tick();
    RSTN = 1'b1;
    apply_rows(0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
